// File: rtl/z_m_sca_stage.sv
// ---------------------------------------------------------------------------
// z_m_sca_stage
//   One stage of a carry-select adder. Two WIDTH-bit ripple-carry adders run
//   side by side on the same operands, one assuming carry-in 0 and one
//   assuming carry-in 1. The real carry-in (c_in) then picks one of the two
//   precomputed {carry, sum} results. That keeps c_in off the ripple path, so
//   stages can be cascaded c_out -> c_in to build wider adders.
//
//   The result is registered: {c_out, sum} = a + b + c_in, one cycle after
//   the inputs are sampled. A new operation may be issued every cycle. There
//   is no valid/ready handshake: every rising edge captures the inputs, and
//   the outputs hold until the next edge.
//
// Ports
//   clk    in   1      system clock, rising edge
//   rst_n  in   1      asynchronous active-low reset; clears sum and c_out
//   a      in   WIDTH  operand A, unsigned
//   b      in   WIDTH  operand B, unsigned
//   c_in   in   1      carry-in; selects the precomputed result
//   sum    out  WIDTH  registered sum bits [WIDTH-1:0]
//   c_out  out  1      registered carry-out (bit WIDTH of a+b+c_in)
// ---------------------------------------------------------------------------
module z_m_sca_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  // Carry chains: bit i is the carry into full adder i, and bit WIDTH is the
  // carry out of the chain.
  logic [WIDTH:0]   carry0;
  logic [WIDTH:0]   carry1;
  logic [WIDTH-1:0] s0;
  logic [WIDTH-1:0] s1;

  // Both ripple chains live in one process. Each carry is written before it
  // is read, so the chain evaluates in a single pass.
  always_comb begin
    carry0    = '0;
    carry1    = '0;
    s0        = '0;
    s1        = '0;
    carry0[0] = 1'b0;
    carry1[0] = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      s0[i]       = a[i] ^ b[i] ^ carry0[i];
      carry0[i+1] = (a[i] & b[i]) | (carry0[i] & (a[i] ^ b[i]));
      s1[i]       = a[i] ^ b[i] ^ carry1[i];
      carry1[i+1] = (a[i] & b[i]) | (carry1[i] & (a[i] ^ b[i]));
    end
  end

  // Select mux: c_in picks the precomputed result.
  logic [WIDTH-1:0] sel_sum;
  logic             sel_carry;

  always_comb begin
    sel_sum   = s0;
    sel_carry = carry0[WIDTH];
    if (c_in) begin
      sel_sum   = s1;
      sel_carry = carry1[WIDTH];
    end
  end

  // Output registers. Reset clears them immediately, so any pending result
  // is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      sum   <= sel_sum;
      c_out <= sel_carry;
    end
  end

endmodule

// File: tb/tb_z_m_sca_stage.sv
// ---------------------------------------------------------------------------
// tb_z_m_sca_stage
//   Self-checking bench for z_m_sca_stage (WIDTH=4). The reference is plain
//   arithmetic: expected {c_out,sum} = a + b + c_in in WIDTH+1 bits. Each
//   operation pushes its expected value onto exp_q. The value is popped and
//   compared one edge later.
// ---------------------------------------------------------------------------
module tb_z_m_sca_stage;

  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic         clk    = 1'b0;
  logic         clk_en = 1'b0;
  logic         rst_n  = 1'b1;
  logic [W-1:0] a      = '0;
  logic [W-1:0] b      = '0;
  logic         c_in   = 1'b0;
  logic [W-1:0] sum;
  logic         c_out;

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  z_m_sca_stage #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .sum   (sum),
    .c_out (c_out)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  logic [W:0] exp_q[$];
  logic [W:0] prev_exp = '0;

  task automatic check(input string tag, input logic [W:0] obs,
                       input logic [W:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1. The task applies the inputs and confirms that the
  // output still holds the previous result. It then waits one edge and
  // checks the new result.
  task automatic drive(input string tag, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic c);
    logic [W:0] e;
    a    = x;
    b    = y;
    c_in = c;
    exp_q.push_back(ref_add(x, y, c));
    #1;
    check({tag, "_hold"}, {c_out, sum}, prev_exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(tag, {c_out, sum}, e);
    prev_exp = e;
  endtask

  // Reset pulse between edges. Called at posedge+1; returns before the
  // next edge with rst_n high again.
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check(tag, {c_out, sum}, '0);
    exp_q.delete();
    prev_exp = '0;
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // 1: reset without any clock edge
    a = 4'hF; b = 4'hF; c_in = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("reset_noclk", {c_out, sum}, '0);
    clk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("reset_hold", {c_out, sum}, '0);
    rst_n = 1'b1;
    prev_exp = '0;

    // 2: max case, stable over 700 ns
    drive("max", 4'hF, 4'hF, 1'b1);
    #700;
    check("max_stable", {c_out, sum}, 5'h1F);

    // 3: zero, then carry-in only
    drive("zero", 4'h0, 4'h0, 1'b0);
    drive("cin_only", 4'h0, 4'h0, 1'b1);

    // 4: wrap-around
    drive("wrap_8_8", 4'h8, 4'h8, 1'b0);
    drive("wrap_7_8_c", 4'h7, 4'h8, 1'b1);

    // 5: no carry, all-ones sum; hold check shows 1-cycle latency
    drive("five_a", 4'h5, 4'hA, 1'b0);

    // 6: exhaustive, with a reset pulse in the middle
    for (int i = 0; i < 512; i++) begin
      drive("exh", i[3:0], i[7:4], i[8]);
      if (i == 300) pulse_reset("reset_mid");
    end

    // Random back-to-back traffic
    for (int i = 0; i < 200; i++) begin
      drive("rand", W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
